// File: rtl/fetch_stage_pkg.sv
// Shared constants and small helpers for the IF stage: reset PC, NOP word and the
// jump/branch target arithmetic used by the next-PC selector.
package fetch_stage_pkg;

  localparam logic [31:0] PcResetDefault = 32'h0000_3000;
  localparam int unsigned ImWordsDefault = 1024;
  localparam logic [31:0] NopWord        = 32'h0000_0000;
  localparam logic [31:0] PcStep         = 32'd4;
  localparam logic [31:0] LinkOffset     = 32'd8;

  // Source chosen for the next fetch address.
  typedef enum logic [1:0] {
    NpcSeq,
    NpcBranch,
    NpcJump,
    NpcReg
  } npc_src_e;

  // Pseudo-direct target: upper nibble of the delay-slot PC, word index below.
  function automatic logic [31:0] jump_target(input logic [3:0]  seg,
                                              input logic [25:0] idx);
    return {seg, idx, 2'b00};
  endfunction

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// Combinational next-PC selector; priority jr > j/jal > beq > sequential.
module fetch_stage_npc_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_pc_d,
  input  logic [31:0] i_pc_f,
  input  logic [25:0] i_instr_idx,
  input  logic [31:0] i_rs_fwd,
  input  logic        i_j,
  input  logic        i_jal,
  input  logic        i_jr,
  input  logic        i_beq_taken,
  output logic [31:0] o_npc
);

  npc_src_e    w_src;
  logic [31:0] w_pc4_d;
  logic [31:0] w_pc4_f;

  assign w_pc4_d = i_pc_d + PcStep;
  assign w_pc4_f = i_pc_f + PcStep;

  always_comb begin
    w_src = NpcSeq;
    if (i_jr) begin
      w_src = NpcReg;
    end else if (i_j || i_jal) begin
      w_src = NpcJump;
    end else if (i_beq_taken) begin
      w_src = NpcBranch;
    end
  end

  always_comb begin
    o_npc = w_pc4_f;
    unique case (w_src)
      NpcReg:    o_npc = i_rs_fwd;
      NpcJump:   o_npc = jump_target(w_pc4_d[31:28], i_instr_idx);
      NpcBranch: o_npc = w_pc4_d + branch_offset(i_instr_idx[15:0]);
      NpcSeq:    o_npc = w_pc4_f;
      default:   o_npc = w_pc4_f;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: PC_F, instruction latch, link value and a sticky
// fetch-error flag for misaligned or out-of-range fetch addresses.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PcResetDefault,
  parameter int unsigned IM_WORDS = ImWordsDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_j,
  input  logic        if_jal,
  input  logic        if_jr,
  input  logic        beq_taken,
  input  logic [31:0] rs_fwd,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        fetch_err
);

  // Bounds held in 33 bits so a range ending at 2^32 does not wrap.
  localparam logic [32:0] PcLo = {1'b0, PC_RESET};
  localparam logic [32:0] PcHi = PcLo + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc8_d;
  logic        r_fetch_err;

  logic [31:0] w_npc;
  logic        w_npc_misaligned;
  logic        w_npc_out_of_range;
  logic        w_npc_bad;

  fetch_stage_npc_sel u_npc_sel (
    .i_pc_d      (r_pc_d),
    .i_pc_f      (r_pc_f),
    .i_instr_idx (r_instr_d[25:0]),
    .i_rs_fwd    (rs_fwd),
    .i_j         (if_j),
    .i_jal       (if_jal),
    .i_jr        (if_jr),
    .i_beq_taken (beq_taken),
    .o_npc       (w_npc)
  );

  assign w_npc_misaligned   = (w_npc[1:0] != 2'b00);
  assign w_npc_out_of_range = ({1'b0, w_npc} < PcLo) || ({1'b0, w_npc} >= PcHi);
  assign w_npc_bad          = w_npc_misaligned || w_npc_out_of_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f      <= PC_RESET;
      r_instr_d   <= NopWord;
      r_pc_d      <= 32'h0;
      r_pc8_d     <= LinkOffset;
      r_fetch_err <= 1'b0;
    end else if (!stall) begin
      // The word fetched this cycle always enters IF/ID: it is the delay slot
      // whenever a transfer is being decided in D.
      r_instr_d   <= im_rdata;
      r_pc_d      <= r_pc_f;
      r_pc8_d     <= r_pc_f + LinkOffset;
      r_pc_f      <= w_npc;
      r_fetch_err <= r_fetch_err | w_npc_bad;
    end
  end

  assign im_addr   = r_pc_f;
  assign instr_D   = r_instr_d;
  assign pc_D      = r_pc_d;
  assign pc8_D     = r_pc8_d;
  assign fetch_err = r_fetch_err;

endmodule
